// File: rtl/rf_pulse_pkg.sv
// rf_pulse_pkg: types, defaults and helpers shared by the RF pulse monitor.
//   pulse_kind_e : classification reported on pulse_kind (NONE/PI2/PI/ERR)
//   mon_state_e  : monitor FSM states
//   sat_inc      : saturating 32-bit increment
//   classify     : width -> PI2/PI/ERR given nominal pi/2 width and tolerance
//   expected_kind: kind expected at a given position of the PI2, PI, PI2 echo
package rf_pulse_pkg;

    localparam int unsigned Pi2CyclesDef     = 333;
    localparam int unsigned TolCyclesDef     = 4;
    localparam int unsigned TimeoutCyclesDef = 200000;
    localparam logic [31:0] CntMax           = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        KindNone = 2'd0,
        KindPi2  = 2'd1,
        KindPi   = 2'd2,
        KindErr  = 2'd3
    } pulse_kind_e;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StArmed = 2'd1,
        StHigh  = 2'd2,
        StLow   = 2'd3
    } mon_state_e;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == CntMax) ? v : v + 32'd1;
    endfunction

    // Widened to 34 bits so nominal + tolerance cannot wrap.
    function automatic pulse_kind_e classify(input logic [31:0] w, input int unsigned pi2,
                                             input int unsigned tol);
        logic [33:0] w34, nom34, pi34, tol34;
        w34   = {2'b00, w};
        nom34 = {2'b00, pi2};
        pi34  = nom34 << 1;
        tol34 = {2'b00, tol};
        if (w == CntMax) begin
            return KindErr;
        end else if ((w34 + tol34 >= nom34) && (w34 <= nom34 + tol34)) begin
            return KindPi2;
        end else if ((w34 + tol34 >= pi34) && (w34 <= pi34 + tol34)) begin
            return KindPi;
        end
        return KindErr;
    endfunction

    function automatic pulse_kind_e expected_kind(input logic [1:0] idx);
        return (idx == 2'd1) ? KindPi : KindPi2;
    endfunction

endpackage

// File: rtl/rf_pulse_monitor_if.sv
// rf_pulse_monitor_if: signal bundle between the pulse monitor and its environment.
//   trig, rf                      : stimulus into the monitor
//   pulse_valid, seq_done, timeout: one-cycle strobes out of the monitor
//   pulse_width, gap_width        : last pulse high width / preceding low gap (cycles)
//   pulse_kind                    : classification of the last pulse
// master = environment side, slave = monitor side.
interface rf_pulse_monitor_if;
    import rf_pulse_pkg::*;

    logic        trig;
    logic        rf;
    logic        pulse_valid;
    logic [31:0] pulse_width;
    logic [31:0] gap_width;
    pulse_kind_e pulse_kind;
    logic        seq_done;
    logic        timeout;

    modport master (
        output trig, rf,
        input  pulse_valid, pulse_width, gap_width, pulse_kind, seq_done, timeout
    );

    modport slave (
        input  trig, rf,
        output pulse_valid, pulse_width, gap_width, pulse_kind, seq_done, timeout
    );

endinterface

// File: rtl/rf_edge_sync.sv
// rf_edge_sync: samples an asynchronous input and flags its rising edge.
//   clk, rst : clock, asynchronous active-high reset
//   d_i      : raw input
//   level_o  : sampled level
//   rise_o   : high for one cycle when the sampled level goes 0 -> 1
// With RF_MON_SYNC_EN defined a 2-flop synchronizer precedes the sample register,
// adding 2 cycles of latency; otherwise the input is sampled by a single register.
module rf_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic level_o,
    output logic rise_o
);

    logic stage;
    logic sample_q;
    logic prev_q;

`ifdef RF_MON_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], d_i};
        end
    end

    assign stage = sync_q[1];
`else
    assign stage = d_i;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_q <= 1'b0;
            prev_q   <= 1'b0;
        end else begin
            sample_q <= stage;
            prev_q   <= sample_q;
        end
    end

    assign level_o = sample_q;
    assign rise_o  = sample_q & ~prev_q;

endmodule

// File: rtl/rf_pulse_monitor.sv
// rf_pulse_monitor: measures RF gate pulses after a trigger, classifies them as
// PI2/PI/ERR and tracks the PI2, PI, PI2 spin-echo sequence.
//   clk, rst : clock, asynchronous active-high reset
//   bus_io   : rf_pulse_monitor_if.slave (trig, rf in; strobes, widths, kind out)
// Parameters: PI2_CYCLES (nominal pi/2 width), TOL_CYCLES (+/- tolerance),
// TIMEOUT_CYCLES (max low gap inside a sequence).
// Macro RF_MON_SYNC_EN (in rf_edge_sync) adds a 2-flop input synchronizer.
module rf_pulse_monitor
    import rf_pulse_pkg::*;
#(
    parameter int unsigned PI2_CYCLES     = Pi2CyclesDef,
    parameter int unsigned TOL_CYCLES     = TolCyclesDef,
    parameter int unsigned TIMEOUT_CYCLES = TimeoutCyclesDef
) (
    input logic                clk,
    input logic                rst,
    rf_pulse_monitor_if.slave  bus_io
);

    logic rf_level, rf_rise, trig_level, trig_rise;

    rf_edge_sync u_rf_sync (
        .clk     (clk),
        .rst     (rst),
        .d_i     (bus_io.rf),
        .level_o (rf_level),
        .rise_o  (rf_rise)
    );

    rf_edge_sync u_trig_sync (
        .clk     (clk),
        .rst     (rst),
        .d_i     (bus_io.trig),
        .level_o (trig_level),
        .rise_o  (trig_rise)
    );

    // Only the trig edge matters; its level is deliberately dropped.
    logic unused_trig_level;
    assign unused_trig_level = trig_level;

    mon_state_e  state_q, state_d;
    logic [31:0] width_q, width_d;
    logic [31:0] gap_q, gap_d;
    logic [31:0] gap_lat_q, gap_lat_d;
    logic [1:0]  idx_q, idx_d;
    logic [31:0] pulse_width_q, pulse_width_d;
    logic [31:0] gap_width_q, gap_width_d;
    pulse_kind_e kind_q, kind_d;
    logic        pulse_valid_q, pulse_valid_d;
    logic        seq_done_q, seq_done_d;
    logic        timeout_q, timeout_d;

    pulse_kind_e meas_kind;
    logic        pulse_ok;
    logic        seq_last;
    logic        gap_expired;

    assign meas_kind   = classify(width_q, PI2_CYCLES, TOL_CYCLES);
    assign pulse_ok    = (meas_kind == expected_kind(idx_q));
    assign seq_last    = (idx_q == 2'd2);
    // gap_q already counts the first low sample taken in StHigh.
    assign gap_expired = (sat_inc(gap_q) >= TIMEOUT_CYCLES);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (trig_rise) state_d = StArmed;
            StArmed: if (rf_rise) state_d = StHigh;
            StHigh: begin
                if (!rf_level) begin
                    if (!pulse_ok) begin
                        state_d = StArmed;
                    end else if (seq_last) begin
                        state_d = StIdle;
                    end else begin
                        state_d = StLow;
                    end
                end
            end
            StLow: begin
                if (rf_rise) begin
                    state_d = StHigh;
                end else if (gap_expired) begin
                    state_d = StArmed;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Counters and registered outputs.
    always_comb begin
        width_d       = width_q;
        gap_d         = gap_q;
        gap_lat_d     = gap_lat_q;
        idx_d         = idx_q;
        pulse_width_d = pulse_width_q;
        gap_width_d   = gap_width_q;
        kind_d        = kind_q;
        pulse_valid_d = 1'b0;
        seq_done_d    = 1'b0;
        timeout_d     = 1'b0;
        unique case (state_q)
            StIdle: idx_d = '0;
            StArmed: begin
                if (rf_rise) begin
                    width_d   = 32'd1;
                    gap_lat_d = '0;  // first pulse of a sequence has no gap
                end
            end
            StHigh: begin
                if (rf_level) begin
                    width_d = sat_inc(width_q);
                end else begin
                    pulse_valid_d = 1'b1;
                    pulse_width_d = width_q;
                    gap_width_d   = gap_lat_q;
                    gap_d         = 32'd1;
                    if (!pulse_ok) begin
                        kind_d = KindErr;
                        idx_d  = '0;
                    end else begin
                        kind_d = meas_kind;
                        if (seq_last) begin
                            seq_done_d = 1'b1;
                            idx_d      = '0;
                        end else begin
                            idx_d = idx_q + 2'd1;
                        end
                    end
                end
            end
            StLow: begin
                if (rf_rise) begin
                    width_d   = 32'd1;
                    gap_lat_d = gap_q;
                end else begin
                    gap_d = sat_inc(gap_q);
                    if (gap_expired) begin
                        timeout_d = 1'b1;
                        idx_d     = '0;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            width_q       <= '0;
            gap_q         <= '0;
            gap_lat_q     <= '0;
            idx_q         <= '0;
            pulse_width_q <= '0;
            gap_width_q   <= '0;
            kind_q        <= KindNone;
            pulse_valid_q <= 1'b0;
            seq_done_q    <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            width_q       <= width_d;
            gap_q         <= gap_d;
            gap_lat_q     <= gap_lat_d;
            idx_q         <= idx_d;
            pulse_width_q <= pulse_width_d;
            gap_width_q   <= gap_width_d;
            kind_q        <= kind_d;
            pulse_valid_q <= pulse_valid_d;
            seq_done_q    <= seq_done_d;
            timeout_q     <= timeout_d;
        end
    end

    assign bus_io.pulse_valid = pulse_valid_q;
    assign bus_io.pulse_width = pulse_width_q;
    assign bus_io.gap_width   = gap_width_q;
    assign bus_io.pulse_kind  = kind_q;
    assign bus_io.seq_done    = seq_done_q;
    assign bus_io.timeout     = timeout_q;

endmodule

// File: tb/tb_rf_pulse_monitor.sv
// tb_rf_pulse_monitor: directed bench for rf_pulse_monitor. A transaction-level
// model turns each driven pulse into expected strobe events (cycle, width, gap,
// kind); a per-cycle checker compares every DUT output against it. Literal checks
// pin the headline results of each scenario. Build with +define+RF_MON_SYNC_EN to
// exercise the synchronised variant (expected latency grows by 2 cycles).
module tb_rf_pulse_monitor;
    import rf_pulse_pkg::*;

    localparam int Pi2 = 333;
    localparam int Tol = 4;
    // Gap timeout shortened from the 200000 default to keep the run short.
    localparam int Tmo = 3000;
`ifdef RF_MON_SYNC_EN
    localparam int Lat = 4;
`else
    localparam int Lat = 2;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    rf_pulse_monitor_if bus ();

    rf_pulse_monitor #(
        .PI2_CYCLES     (Pi2),
        .TOL_CYCLES     (Tol),
        .TIMEOUT_CYCLES (Tmo)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        bit pv;
        bit sd;
        bit to;
        int w;
        int g;
        int k;
    } ev_t;

    ev_t evq[$];
    int  tests = 0;
    int  fails = 0;
    int  cyc   = 0;
    int  exp_w = 0, exp_g = 0, exp_k = 0;
    int  m_state = 0;  // 0 idle, 1 armed, 2 inside a sequence (low gap)
    int  m_idx = 0;
    int  m_prev_low = 0;
    int  m_last_fall = 0;
    int  pv_seen = 0, sd_seen = 0, to_seen = 0, last_pv_cyc = 0;
    bit  e_pv, e_sd, e_to;

    task automatic check(input string name, input longint act, input longint req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, req);
        end
    endtask

    function automatic int classify_m(input int w);
        int d1, d2;
        d1 = (w > Pi2) ? w - Pi2 : Pi2 - w;
        d2 = (w > 2 * Pi2) ? w - 2 * Pi2 : 2 * Pi2 - w;
        if (d1 <= Tol) return 1;
        if (d2 <= Tol) return 2;
        return 3;
    endfunction

    task automatic model_reset();
        evq.delete();
        exp_w = 0;
        exp_g = 0;
        exp_k = 0;
        m_state = 0;
        m_idx = 0;
        m_prev_low = 0;
    endtask

    // Per-cycle comparison against the model, sampled 1 time unit after the edge.
    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        if (!rst) begin
            while (evq.size() > 0 && evq[0].cyc < cyc) begin
                check("event_missed", cyc, evq[0].cyc);
                void'(evq.pop_front());
            end
            e_pv = 1'b0;
            e_sd = 1'b0;
            e_to = 1'b0;
            if (evq.size() > 0 && evq[0].cyc == cyc) begin
                e_pv = evq[0].pv;
                e_sd = evq[0].sd;
                e_to = evq[0].to;
                if (evq[0].pv) begin
                    exp_w = evq[0].w;
                    exp_g = evq[0].g;
                    exp_k = evq[0].k;
                end
                void'(evq.pop_front());
            end
            check("pulse_valid", bus.pulse_valid, e_pv);
            check("seq_done", bus.seq_done, e_sd);
            check("timeout", bus.timeout, e_to);
            check("pulse_width", bus.pulse_width, exp_w);
            check("gap_width", bus.gap_width, exp_g);
            check("pulse_kind", bus.pulse_kind, exp_k);
            if (bus.pulse_valid) begin
                pv_seen++;
                last_pv_cyc = cyc;
            end
            if (bus.seq_done) sd_seen++;
            if (bus.timeout) to_seen++;
        end
    end

    task automatic check_zero(input string tag);
        check({tag, "_pulse_valid"}, bus.pulse_valid, 0);
        check({tag, "_seq_done"}, bus.seq_done, 0);
        check({tag, "_timeout"}, bus.timeout, 0);
        check({tag, "_pulse_width"}, bus.pulse_width, 0);
        check({tag, "_gap_width"}, bus.gap_width, 0);
        check({tag, "_pulse_kind"}, bus.pulse_kind, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        check_zero("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_trig();
        bus.trig = 1'b1;
        repeat (2) @(negedge clk);
        bus.trig = 1'b0;
        repeat (4) @(negedge clk);
        if (m_state == 0) begin
            m_state = 1;
            m_idx = 0;
        end
    endtask

    // Drive rf high for high_len cycles then low for low_len cycles.
    task automatic pulse(input int high_len, input int low_len);
        ev_t ev;
        int  k, want;
        bus.rf = 1'b1;
        repeat (high_len) @(negedge clk);
        bus.rf = 1'b0;
        m_last_fall = cyc;
        if (m_state != 0) begin
            k = classify_m(high_len);
            want = (m_idx == 1) ? 2 : 1;
            ev.cyc = m_last_fall + Lat;
            ev.pv = 1'b1;
            ev.to = 1'b0;
            ev.w = high_len;
            ev.g = (m_state == 2) ? m_prev_low : 0;
            if (k != want) begin
                ev.k = 3;
                ev.sd = 1'b0;
                m_state = 1;
                m_idx = 0;
            end else if (m_idx == 2) begin
                ev.k = k;
                ev.sd = 1'b1;
                m_state = 0;
                m_idx = 0;
            end else begin
                ev.k = k;
                ev.sd = 1'b0;
                m_state = 2;
                m_idx++;
            end
            evq.push_back(ev);
            if (m_state == 2 && low_len >= Tmo) begin
                ev.cyc = m_last_fall + Lat + Tmo - 1;
                ev.pv = 1'b0;
                ev.sd = 1'b0;
                ev.to = 1'b1;
                evq.push_back(ev);
                m_state = 1;
                m_idx = 0;
            end
        end
        m_prev_low = low_len;
        repeat (low_len) @(negedge clk);
    endtask

    int pv0, sd0, to0;

    initial begin
        bus.trig = 1'b0;
        bus.rf = 1'b0;
        repeat (3) @(negedge clk);
        do_reset();

        // Single pi/2 pulse.
        do_trig();
        pv0 = pv_seen;
        pulse(333, 20);
        check("s1_count", pv_seen - pv0, 1);
        check("s1_width", bus.pulse_width, 333);
        check("s1_kind", bus.pulse_kind, 1);
        check("s1_gap", bus.gap_width, 0);
        check("s1_latency", last_pv_cyc - m_last_fall, Lat);

        // Full echo sequence, then rf ignored in idle.
        do_reset();
        do_trig();
        sd0 = sd_seen;
        pulse(333, 1000);
        pulse(666, 1000);
        pulse(333, 20);
        check("s2_seq_done", sd_seen - sd0, 1);
        check("s2_gap", bus.gap_width, 1000);
        check("s2_kind", bus.pulse_kind, 1);
        check("s2_state", dut.state_q, StIdle);
        pv0 = pv_seen;
        pulse(333, 20);
        check("s2_idle_ignores_rf", pv_seen - pv0, 0);

        // Out-of-tolerance width.
        do_reset();
        do_trig();
        sd0 = sd_seen;
        pulse(500, 20);
        check("s3_kind", bus.pulse_kind, 3);
        check("s3_seq_done", sd_seen - sd0, 0);
        check("s3_state", dut.state_q, StArmed);

        // Gap timeout.
        do_reset();
        do_trig();
        sd0 = sd_seen;
        to0 = to_seen;
        pulse(333, Tmo + 20);
        check("s4_timeout", to_seen - to0, 1);
        check("s4_seq_done", sd_seen - sd0, 0);
        check("s4_state", dut.state_q, StArmed);

        // Gap one short of the timeout continues the sequence.
        do_reset();
        do_trig();
        to0 = to_seen;
        pulse(333, Tmo - 1);
        pulse(666, 20);
        check("s5_timeout", to_seen - to0, 0);
        check("s5_gap", bus.gap_width, Tmo - 1);
        check("s5_kind", bus.pulse_kind, 2);

        // Reset in the middle of a pulse.
        do_reset();
        do_trig();
        pulse(333, 50);
        bus.rf = 1'b1;
        repeat (100) @(negedge clk);
        rst = 1'b1;
        #1;
        model_reset();
        check_zero("s6_midpulse_reset");
        @(negedge clk);
        rst = 1'b0;
        pv0 = pv_seen;
        repeat (200) @(negedge clk);
        bus.rf = 1'b0;
        repeat (30) @(negedge clk);
        check("s6_no_pulse_valid", pv_seen - pv0, 0);
        check("s6_state", dut.state_q, StIdle);

        // Tolerance edges and input latency.
        do_reset();
        do_trig();
        pulse(337, 20);
        check("s7_337_kind", bus.pulse_kind, 1);
        check("s7_337_latency", last_pv_cyc - m_last_fall, Lat);
        do_reset();
        do_trig();
        pulse(338, 20);
        check("s7_338_kind", bus.pulse_kind, 3);
        check("s7_338_latency", last_pv_cyc - m_last_fall, Lat);
        pulse(329, 20);
        check("s7_329_kind", bus.pulse_kind, 1);
        pulse(670, 20);
        check("s7_670_kind", bus.pulse_kind, 2);
        pulse(328, 20);
        check("s7_328_kind", bus.pulse_kind, 3);

        repeat (10) @(negedge clk);
        check("events_drained", evq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
